// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong constants, bounce codes and ball state type
// Contents: screen size defaults, 2-bit bounce event codes, ball_state_t,
//           centre() helper for the serve position.
package pong_pkg;

    localparam int SCREEN_X_DEF = 640;
    localparam int SCREEN_Y_DEF = 480;

    localparam logic [1:0] BOUNCE_NONE   = 2'd0;
    localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
    localparam logic [1:0] BOUNCE_WALL   = 2'd2;
    localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } ball_state_t;

    // Left/top edge that places a ball of the given size in the middle of the screen.
    function automatic logic [9:0] centre(input int screen, input int size);
        return 10'((screen - size) / 2);
    endfunction

endpackage

// File: rtl/ball_fsm_if.sv
// rtl/ball_fsm_if.sv - event/position bundle between collision logic and ball_fsm
// Signals: tick, bounce (collision side -> ball); ball_pos_x/y, ball_size_x/y,
//          dir_x, dir_y, serving (ball -> collision logic and renderer).
// Modports: master = collision/score side, slave = ball_fsm.
interface ball_fsm_if;
    logic       tick;
    logic [1:0] bounce;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic [7:0] ball_size_x;
    logic [7:0] ball_size_y;
    logic       dir_x;
    logic       dir_y;
    logic       serving;

    modport master (
        output tick, bounce,
        input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
    );

    modport slave (
        input  tick, bounce,
        output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
    );
endinterface

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one-axis ball step with saturation at 0 and max_i
// Ports: pos_i current edge, dir_i 1 = increasing, speed_i step size,
//        max_i largest legal edge, pos_o stepped and clamped edge.
module ball_axis_step (
    input  logic [9:0] pos_i,
    input  logic       dir_i,
    input  logic [9:0] speed_i,
    input  logic [9:0] max_i,
    output logic [9:0] pos_o
);

    logic [10:0] sum;

    always_comb begin
        sum   = 11'd0;
        pos_o = pos_i;
        if (dir_i) begin
            sum   = {1'b0, pos_i} + {1'b0, speed_i};
            pos_o = (sum > {1'b0, max_i}) ? max_i : sum[9:0];
        end else begin
            // Bit 10 is the borrow: the step would go below zero.
            sum   = {1'b0, pos_i} - {1'b0, speed_i};
            pos_o = sum[10] ? 10'd0 : sum[9:0];
        end
    end

endmodule

// File: rtl/ball_fsm.sv
// rtl/ball_fsm.sv - pong ball motion controller (serve countdown, play, bounces)
// Ports: clock, reset_n (sync active-low), bus (ball_fsm_if.slave):
//        tick/bounce in; ball_pos_x/y, ball_size_x/y, dir_x/y, serving out.
module ball_fsm
    import pong_pkg::*;
#(
    parameter int SCREEN_X    = SCREEN_X_DEF,
    parameter int SCREEN_Y    = SCREEN_Y_DEF,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 2,
    parameter int SERVE_TICKS = 60
) (
    input  logic             clock,
    input  logic             reset_n,
    ball_fsm_if.slave        bus
);

    localparam logic [9:0] CX      = centre(SCREEN_X, BALL_SIZE);
    localparam logic [9:0] CY      = centre(SCREEN_Y, BALL_SIZE);
    localparam logic [9:0] MAX_X   = 10'(SCREEN_X - BALL_SIZE);
    localparam logic [9:0] MAX_Y   = 10'(SCREEN_Y - BALL_SIZE);
    localparam logic [9:0] SPD_X   = 10'(SPEED_X);
    localparam logic [9:0] SPD_Y   = 10'(SPEED_Y);
    localparam logic [7:0] RELOAD  = 8'(SERVE_TICKS);

    ball_state_t state_q;
    logic [9:0]  pos_x_q, pos_y_q;
    logic        dir_x_q, dir_y_q;
    logic [7:0]  cnt_q;
    logic        armed_q;
    logic        serving_q;

    logic        act;
    logic        dir_x_d, dir_y_d;
    logic [9:0]  pos_x_d, pos_y_d;

    // An event is acted on only once per assertion: armed_q re-arms on a zero code.
    assign act     = (state_q == PLAY) && armed_q && (bus.bounce != BOUNCE_NONE);
    // Post-flip directions, so a move in the same cycle as a bounce goes the new way.
    assign dir_x_d = dir_x_q ^ (act && (bus.bounce == BOUNCE_PADDLE));
    assign dir_y_d = dir_y_q ^ (act && (bus.bounce == BOUNCE_WALL));

    ball_axis_step u_step_x (
        .pos_i   (pos_x_q),
        .dir_i   (dir_x_d),
        .speed_i (SPD_X),
        .max_i   (MAX_X),
        .pos_o   (pos_x_d)
    );

    ball_axis_step u_step_y (
        .pos_i   (pos_y_q),
        .dir_i   (dir_y_d),
        .speed_i (SPD_Y),
        .max_i   (MAX_Y),
        .pos_o   (pos_y_d)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= SERVE;
            pos_x_q   <= CX;
            pos_y_q   <= CY;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= RELOAD;
            armed_q   <= 1'b0;
            serving_q <= 1'b1;
        end else begin
            case (state_q)
                SERVE: begin
                    if (bus.tick) begin
                        if (cnt_q == 8'd0) begin
                            state_q   <= PLAY;
                            serving_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                PLAY: begin
                    if (bus.bounce == BOUNCE_NONE) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                    end
                    if (act && (bus.bounce == BOUNCE_SCORE)) begin
                        // Score beats a coincident tick; flip x so serves alternate.
                        pos_x_q   <= CX;
                        pos_y_q   <= CY;
                        dir_x_q   <= ~dir_x_q;
                        cnt_q     <= RELOAD;
                        state_q   <= SERVE;
                        serving_q <= 1'b1;
                    end else begin
                        dir_x_q <= dir_x_d;
                        dir_y_q <= dir_y_d;
                        if (bus.tick) begin
                            pos_x_q <= pos_x_d;
                            pos_y_q <= pos_y_d;
                        end
                    end
                end
                default: state_q <= SERVE;
            endcase
        end
    end

    assign bus.ball_pos_x  = pos_x_q;
    assign bus.ball_pos_y  = pos_y_q;
    assign bus.ball_size_x = 8'(BALL_SIZE);
    assign bus.ball_size_y = 8'(BALL_SIZE);
    assign bus.dir_x       = dir_x_q;
    assign bus.dir_y       = dir_y_q;
    assign bus.serving     = serving_q;

endmodule

// File: tb/tb_ball_fsm.sv
// tb/tb_ball_fsm.sv - self-checking bench for ball_fsm with SERVE_TICKS=3
module tb_ball_fsm;

    typedef struct {
        logic       rn;
        logic       tk;
        logic [1:0] bc;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       edx;
        logic       edy;
        logic       esv;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    ball_fsm_if bif ();

    ball_fsm #(
        .SCREEN_X    (640),
        .SCREEN_Y    (480),
        .BALL_SIZE   (8),
        .SPEED_X     (2),
        .SPEED_Y     (2),
        .SERVE_TICKS (3)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rn, input logic tk, input logic [1:0] bc,
                               input int ex, input int ey,
                               input logic edx, input logic edy, input logic esv);
        vec_t r;
        r.rn = rn; r.tk = tk; r.bc = bc;
        r.ex = 10'(ex); r.ey = 10'(ey);
        r.edx = edx; r.edy = edy; r.esv = esv;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic step(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        reset_n    = t.rn;
        bif.tick   = t.tk;
        bif.bounce = t.bc;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".x"},       {22'd0, bif.ball_pos_x}, {22'd0, e.ex});
        chk({tag, ".y"},       {22'd0, bif.ball_pos_y}, {22'd0, e.ey});
        chk({tag, ".dir_x"},   {31'd0, bif.dir_x},      {31'd0, e.edx});
        chk({tag, ".dir_y"},   {31'd0, bif.dir_y},      {31'd0, e.edy});
        chk({tag, ".serving"}, {31'd0, bif.serving},    {31'd0, e.esv});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int y;
        reset_n    = 1'b0;
        bif.tick   = 1'b0;
        bif.bounce = 2'd0;

        // Reset with tick toggling, serve countdown, held wall event.
        tbl.push_back(v(0, 1, 0, 316, 236, 1, 1, 1));
        tbl.push_back(v(0, 0, 0, 316, 236, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 316, 236, 1, 1, 1));   // tick 1
        tbl.push_back(v(1, 0, 0, 316, 236, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 316, 236, 1, 1, 1));   // tick 2
        tbl.push_back(v(1, 0, 0, 316, 236, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 316, 236, 1, 1, 1));   // tick 3
        tbl.push_back(v(1, 0, 0, 316, 236, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 316, 236, 1, 1, 0));   // tick 4: to PLAY, no move
        tbl.push_back(v(1, 0, 0, 316, 236, 1, 1, 0));   // arms
        tbl.push_back(v(1, 1, 0, 318, 238, 1, 1, 0));   // tick 5: first move
        tbl.push_back(v(1, 0, 0, 318, 238, 1, 1, 0));
        tbl.push_back(v(1, 0, 2, 318, 238, 1, 0, 0));   // wall acted once
        tbl.push_back(v(1, 1, 2, 320, 236, 1, 0, 0));
        tbl.push_back(v(1, 0, 2, 320, 236, 1, 0, 0));
        tbl.push_back(v(1, 1, 2, 322, 234, 1, 0, 0));
        tbl.push_back(v(1, 0, 2, 322, 234, 1, 0, 0));
        tbl.push_back(v(1, 0, 2, 322, 234, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 322, 234, 1, 0, 0));   // re-arm
        tbl.push_back(v(1, 0, 2, 322, 234, 1, 1, 0));   // flips back
        tbl.push_back(v(1, 0, 0, 322, 234, 1, 1, 0));
        tbl.push_back(v(1, 1, 0, 324, 236, 1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end
        chk("size_x", {24'd0, bif.ball_size_x}, 32'd8);
        chk("size_y", {24'd0, bif.ball_size_y}, 32'd8);

        // Walk to x=400 (y follows down).
        for (int k = 1; k <= 38; k++) begin
            x = 324 + 2 * k;
            y = 236 + 2 * k;
            step(v(1, 1, 0, x, y, 1, 1, 0), "walk_tick");
            step(v(1, 0, 0, x, y, 1, 1, 0), "walk_idle");
        end

        // Paddle and tick together: move uses the new direction.
        step(v(1, 1, 1, 398, 314, 0, 1, 0), "paddle_tick");
        step(v(1, 0, 0, 398, 314, 0, 1, 0), "paddle_rearm");

        // Held score, with a tick on the scoring edge and one during serve.
        step(v(1, 1, 3, 316, 236, 1, 1, 1), "score0");
        step(v(1, 0, 3, 316, 236, 1, 1, 1), "score1");
        step(v(1, 1, 3, 316, 236, 1, 1, 1), "score2");
        step(v(1, 0, 3, 316, 236, 1, 1, 1), "score3");
        step(v(1, 1, 0, 316, 236, 1, 1, 1), "reserve_t2");
        step(v(1, 0, 0, 316, 236, 1, 1, 1), "reserve_i2");
        step(v(1, 1, 0, 316, 236, 1, 1, 1), "reserve_t3");
        step(v(1, 0, 0, 316, 236, 1, 1, 1), "reserve_i3");
        step(v(1, 1, 0, 316, 236, 1, 1, 0), "reserve_play");
        step(v(1, 0, 0, 316, 236, 1, 1, 0), "reserve_arm");
        step(v(1, 1, 0, 318, 238, 1, 1, 0), "reserve_move");
        step(v(1, 0, 0, 318, 238, 1, 1, 0), "reserve_idle");

        // Run into the bottom-right corner and hold there.
        for (int k = 1; k <= 165; k++) begin
            x = 318 + 2 * k;
            y = 238 + 2 * k;
            if (x > 632) x = 632;
            if (y > 472) y = 472;
            step(v(1, 1, 0, x, y, 1, 1, 0), "clamp_tick");
            step(v(1, 0, 0, x, y, 1, 1, 0), "clamp_idle");
        end

        // Mid-play reset (with a tick present), then no move on the next tick.
        step(v(0, 1, 0, 316, 236, 1, 1, 1), "midreset");
        step(v(1, 1, 0, 316, 236, 1, 1, 1), "post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ball_fsm.md
# ball_fsm

Ball motion controller for the pong datapath. It consumes the 2-bit `bounce` event code produced by the collision/score logic and owns the ball's position and direction. It drives `ball_pos_x/y` and `ball_size_x/y` back to that logic and to the renderer. Per frame tick it steps the ball, reflects it on paddle/wall events, and re-serves from screen centre after a score.

## Interface
- `SCREEN_X`, 640, screen width in pixels
- `SCREEN_Y`, 480, screen height in pixels
- `BALL_SIZE`, 8, ball width and height in pixels (≤255)
- `SPEED_X`, 2, pixels moved in x per tick
- `SPEED_Y`, 2, pixels moved in y per tick
- `SERVE_TICKS`, 60, ticks the ball is held at centre before play (≤255)

- `clock`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `tick`  in  1  one-cycle frame-rate move strobe
- `bounce`  in  2  event code: 0 none, 1 paddle, 2 wall, 3 score
- `ball_pos_x`  out  10  ball left edge
- `ball_pos_y`  out  10  ball top edge
- `ball_size_x`  out  8  constant `BALL_SIZE`
- `ball_size_y`  out  8  constant `BALL_SIZE`
- `dir_x`  out  1  1 = moving right, 0 = left
- `dir_y`  out  1  1 = moving down, 0 = up
- `serving`  out  1  high while in SERVE state

## Operation
- Defines the centre position as CX = (SCREEN_X−BALL_SIZE)/2 and CY = (SCREEN_Y−BALL_SIZE)/2. With the defaults these are 316 and 236.
- Reset values: state SERVE; `ball_pos_x`=CX; `ball_pos_y`=CY; `dir_x`=1; `dir_y`=1; serve counter=SERVE_TICKS; `armed`=0; `serving`=1.
- SERVE state:
  - Position is held at the centre and `bounce` is ignored.
  - On each `tick`, the counter decrements if it is nonzero.
  - On a `tick` with the counter at 0, the block moves to PLAY. The ball does not move on that tick.
- PLAY state, event handling:
  - Events are edge-qualified by `armed`. When `bounce`=0, `armed` is set to 1. When `bounce`≠0 and `armed`=1, the event is acted on and `armed` is cleared. A held code therefore acts exactly once.
  - Paddle event (1): `dir_x` inverts.
  - Wall event (2): `dir_y` inverts.
  - Score event (3) performs all of the following:
    - Position returns to the centre.
    - `dir_x` inverts, so serves alternate sides.
    - `dir_y` is unchanged.
    - The counter reloads to SERVE_TICKS.
    - State becomes SERVE and `armed` is cleared.
- PLAY state, motion on `tick`:
  - x becomes x±SPEED_X and y becomes y±SPEED_Y, with the sign taken from the direction bits.
  - The sums are computed 11 bits wide and clamped to [0, SCREEN_X−BALL_SIZE] and [0, SCREEN_Y−BALL_SIZE]. Position never wraps.
- Simultaneous events in the same cycle:
  - An acted-on paddle or wall event together with `tick`: the move uses the post-flip direction.
  - Score together with `tick`: score wins and no move occurs.
- Reset mid-operation: a `reset_n` low sample restores all reset values on that edge, whatever the state.

## Timing
- All outputs are registered.
- Direction flip latency: 1 clock after the event is sampled.
- Position update latency: 1 clock after the `tick` sample.
- Score to centre: `ball_pos_*` equals the centre and `serving`=1 on the edge that samples `bounce`=3.
- First movement after reset: SERVE_TICKS+2 ticks after reset. That is SERVE_TICKS decrementing ticks, one transition tick, then the first move tick.
- `tick` is assumed no faster than 1 per 2 clocks, so the collision logic's one-cycle-late `bounce` is seen before the next move.

## Structure
- Shared package `pong_pkg` holds:
  - the SCREEN_X/SCREEN_Y defaults;
  - the bounce codes BOUNCE_NONE/PADDLE/WALL/SCORE;
  - the `ball_state_t` enum {SERVE, PLAY}.
- Sub-module `ball_axis_step` (pos, dir, speed, max → next pos, clamped) is instantiated once per axis.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 clocks with `tick` toggling. Then `ball_pos`=(316,236), `dir_x`=`dir_y`=1, sizes 8/8, `serving`=1, and there is no movement.
- **Serve countdown:** set SERVE_TICKS=3 and `bounce`=0.
  - Ticks 1–3: position stays at (316,236).
  - Tick 4: `serving` drops to 0 and the ball does not move.
  - Tick 5: position is (318,238).
- **Held wall event:** in PLAY, hold `bounce`=2 for 6 clocks spanning 2 ticks. `dir_y` flips exactly once and y decreases by 2 per tick. Then `bounce`=0 for 1 clock, then `bounce`=2 again: `dir_y` flips back.
- **Simultaneous paddle event and tick:** in PLAY with `dir_x`=1 and x=400, assert `bounce`=1 (armed) and `tick` in the same cycle. Result: x=398 and `dir_x`=0.
- **Score:** in PLAY at (500,100), hold `bounce`=3 for 4 clocks. On the first edge: centre (316,236), `serving`=1, `dir_x` inverted, counter at 3. The held code has no further effect.
- **Clamp and reset:** run with `bounce`=0 and `dir_x`=1.
  - x saturates at 632 and holds across further ticks.
  - y saturates at 472.
  - Then assert `reset_n`=0 for 1 clock mid-PLAY: all reset values are restored on that edge.
